// File: rtl/disp_pkg.sv
// disp_pkg: shared segment type and special digit codes for the display scan controller
package disp_pkg;

    typedef logic [6:0] seg_t;

    localparam int   NUM_DASH  = 11;
    localparam int   NUM_BLANK = 12;
    localparam seg_t SEG_OFF   = 7'h7F;
    localparam seg_t SEG_DASH  = 7'h3F;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: digit code to active-low {g,f,e,d,c,b,a} segment pattern
module seg7_decode
    import disp_pkg::*;
(
    input  logic [10:0] num,
    output seg_t        seg
);

    // 0..9 map to the usual glyphs, 11 is a dash, every other code is blank
    always_comb begin
        seg = SEG_OFF;
        case (num)
            11'd0:           seg = 7'b1000000;
            11'd1:           seg = 7'b1111001;
            11'd2:           seg = 7'b0100100;
            11'd3:           seg = 7'b0110000;
            11'd4:           seg = 7'b0011001;
            11'd5:           seg = 7'b0010010;
            11'd6:           seg = 7'b0000010;
            11'd7:           seg = 7'b1111000;
            11'd8:           seg = 7'b0000000;
            11'd9:           seg = 7'b0010000;
            11'(NUM_DASH):   seg = SEG_DASH;
            default:         seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 8-digit 7-segment scan sequencer with inter-digit blanking; optional blinking under DISP_BLINK_EN
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int SCAN_HZ      = 1000,
    parameter int BLANK_CYC    = 16,
    parameter int DIGITS       = 8,
    parameter int BLINK_FRAMES = 62
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [10:0] num,
    input  logic        dot,
    input  logic [7:0]  blink_mask,
    output logic [2:0]  light,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [2:0]    light_q, light_d;
    logic [7:0]    an_q, an_d;
    seg_t          seg_q, seg_d, dec;
    logic          dp_q, dp_d;
    logic          fd_q, fd_d;
    logic          slot_end, wrap, sample, suppress;

    assign slot_end = pcnt_q == PW'(DIV - 1);
    assign wrap     = en && slot_end && light_q == 3'(DIGITS - 1);
    assign sample   = en && pcnt_q == PW'(BLANK_CYC - 1);

    seg7_decode u_dec (
        .num (num),
        .seg (dec)
    );

`ifdef DISP_BLINK_EN
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          phase_q, phase_d;
    logic          half_end;

    assign half_end = wrap && fcnt_q == FW'(BLINK_FRAMES - 1);

    // frame counter advances on each wrap; phase flips every BLINK_FRAMES frames, both clear while disabled
    always_comb begin
        fcnt_d  = !en ? '0 : half_end ? '0 : wrap ? fcnt_q + 1'b1 : fcnt_q;
        phase_d = en && (phase_q ^ half_end);
    end

    // next-state values drive the suppression so it lines up with the registered anodes
    assign suppress = phase_d && blink_mask[light_d];

    // blink state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
        end
    end
`else
    logic blink_unused;
    localparam int blink_frames_unused = BLINK_FRAMES;

    assign blink_unused = ^blink_mask;
    assign suppress     = 1'b0;
`endif

    // prescaler, digit counter, anode blanking and segment sampling; anodes follow the next pcnt so they align with it
    always_comb begin
        pcnt_d  = (!en || slot_end) ? '0 : pcnt_q + 1'b1;
        light_d = !en ? '0 : !slot_end ? light_q : light_q == 3'(DIGITS - 1) ? '0 : light_q + 3'd1;
        an_d    = (!en || pcnt_d < PW'(BLANK_CYC) || suppress) ? 8'hFF : ~(8'd1 << light_d);
        seg_d   = sample ? dec : seg_q;
        dp_d    = sample ? dot : dp_q;
        fd_d    = wrap;
    end

    // all outputs are registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q  <= '0;
            light_q <= '0;
            an_q    <= 8'hFF;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
            fd_q    <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            light_q <= light_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            fd_q    <= fd_d;
        end
    end

    assign light      = light_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: table vectors, directed corner sequences and random stimulus against a slot/frame arithmetic model
module tb_display_scan_ctrl;

    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [10:0] num = '0;
    logic        dot = 1'b1;
    logic [7:0]  blink_mask = 8'h03;
    logic [2:0]  light;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    int         k = 0;
    logic       m_on = 1'b0;
    logic [6:0] m_seg = 7'h7F;
    logic       m_dp = 1'b1;

    logic [6:0] dig_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct {
        logic [10:0] num;
        logic        dot;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;

    vec_t tab [8];

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .CLK_HZ       (1000),
        .SCAN_HZ      (100),
        .BLANK_CYC    (2),
        .DIGITS       (8),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .num        (num),
        .dot        (dot),
        .blink_mask (blink_mask),
        .light      (light),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    function automatic logic [6:0] ref_dec(input int n);
        if (n <= 9) return dig_tab[n];
        return n == 11 ? 7'h3F : 7'h7F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k);
        end
    endtask

    task automatic check_all();
        int pc, lt, fr;
        logic [7:0] e_an;
        pc = k % 10;
        lt = (k / 10) % 8;
        fr = k / 80;
        e_an = (!m_on || pc < 2) ? 8'hFF : ~(8'd1 << lt);
`ifdef DISP_BLINK_EN
        if (m_on && ((fr / BF) % 2) == 1 && blink_mask[lt]) e_an = 8'hFF;
`endif
        check("an", an, e_an);
        check("light", light, m_on ? lt : 0);
        check("frame_done", frame_done, m_on && k > 0 && pc == 0 && lt == 0);
        check("seg", seg, m_seg);
        check("dp", dp, m_dp);
    endtask

    task automatic step();
        @(posedge clk);
        if (en) begin
            if (k % 10 == 1) begin
                m_seg = ref_dec(int'(num));
                m_dp  = dot;
            end
            k++;
        end else begin
            k = 0;
        end
        m_on = en;
        #1 check_all();
    endtask

    int fd_cnt;

    initial begin
        tab[0] = '{11'd0,    1'b0, 7'h40, 1'b0};
        tab[1] = '{11'd11,   1'b0, 7'h3F, 1'b0};
        tab[2] = '{11'd12,   1'b0, 7'h7F, 1'b0};
        tab[3] = '{11'd15,   1'b0, 7'h7F, 1'b0};
        tab[4] = '{11'd8,    1'b1, 7'h00, 1'b1};
        tab[5] = '{11'd3,    1'b0, 7'h30, 1'b0};
        tab[6] = '{11'd10,   1'b1, 7'h7F, 1'b1};
        tab[7] = '{11'd2047, 1'b0, 7'h7F, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_an", an, 8'hFF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        check("rst_light", light, 0);
        check("rst_fd", frame_done, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        en = 1'b1; num = 11'd8; dot = 1'b1;
        fd_cnt = 0;
        repeat (170) begin
            step();
            if (frame_done) fd_cnt++;
        end
        check("fd_pulses", fd_cnt, 2);

        for (int i = 0; i < 100 && k % 80 != 45; i++) step();
        check("pre_rst_an", an, 8'hEF);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_an", an, 8'hFF);
        check("async_rst_seg", seg, 7'h7F);
        check("async_rst_dp", dp, 1'b1);
        check("async_rst_light", light, 0);
        k = 0; m_on = 1'b0; m_seg = 7'h7F; m_dp = 1'b1;
        @(negedge clk) rst_n = 1'b1;

        foreach (tab[i]) begin
            num = tab[i].num;
            dot = tab[i].dot;
            repeat (10) step();
            check("tab_seg", seg, tab[i].seg);
            check("tab_dp", dp, tab[i].dp);
        end

        for (int i = 0; i < 20 && k % 10 != 0; i++) step();
        num = 11'd3; dot = 1'b0;
        repeat (5) step();
        num = 11'd7;
        repeat (4) step();
        check("hold_old", seg, 7'h30);
        repeat (3) step();
        check("take_new", seg, 7'h78);

        for (int i = 0; i < 100 && ((k / 10) % 8 != 5 || k % 10 != 4); i++) step();
        check("pre_dis_light", light, 5);
        en = 1'b0;
        step();
        check("dis_an", an, 8'hFF);
        check("dis_light", light, 0);
        repeat (3) step();
        en = 1'b1;
        step();
        check("reen_blank1", an, 8'hFF);
        step();
        check("reen_lit", an, 8'hFE);

        while (k < 165) begin
            num = 11'($urandom_range(0, 15));
            dot = 1'($urandom_range(0, 1));
            step();
        end
`ifdef DISP_BLINK_EN
        check("blink_dark", an, 8'hFF);
`else
        check("blink_lit", an, 8'hFE);
`endif
        for (int i = 0; i < 300; i++) begin
            num = 11'($urandom_range(0, 15));
            dot = 1'($urandom_range(0, 1));
            step();
        end

        for (int i = 0; i < 3000; i++) begin
            num = ($urandom_range(0, 19) == 0) ? 11'($urandom) : 11'($urandom_range(0, 13));
            dot = 1'($urandom_range(0, 1));
            en  = $urandom_range(0, 299) != 0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
